uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per UART frame.
REQ-002 Parameter STOP_BITS, default 1, stop bits per frame (legal values 1 or 2).
REQ-003 clk  in  1  system clock, 25 MHz.
REQ-004 rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 req0_valid  in  1  requester 0 has a byte to send.
REQ-006 req0_data  in  DATA_W  requester 0 payload.
REQ-007 req0_ready  out  1  requester 0 byte accepted this cycle.
REQ-008 req1_valid  in  1  requester 1 has a byte to send.
REQ-009 req1_data  in  DATA_W  requester 1 payload.
REQ-010 req1_ready  out  1  requester 1 byte accepted this cycle.
REQ-011 bps_start  out  1  enable to the external baud generator; the generator counter runs only while this is high.
REQ-012 clk_bps  in  1  one-cycle baud tick from the baud generator; it is the bit-change point.
REQ-013 uart_tx  out  1  serial line; idles high.
REQ-014 busy  out  1  a frame is in progress.
REQ-015 grant_id  out  1  source of the current or most recent frame.

Function
REQ-016 States SHALL be IDLE, WAIT_START, SHIFT and GAP.
REQ-017 Transfer rule: reqN_ready SHALL be combinational, high only in IDLE for the arbitration winner; a transfer occurs when validN && readyN.
REQ-018 Arbitration SHALL be round-robin with a last_grant pointer:
- only one requester valid: that requester wins;
- both valid: the requester other than last_grant wins;
- last_grant resets to 1, so req0 wins the first contention.
REQ-019 On a transfer, the block SHALL latch the payload and grant_id, update last_grant, set bps_start=1 and busy=1 at the next edge, and enter WAIT_START.
REQ-020 Payload changes after acceptance SHALL NOT affect the frame.
REQ-021 Frame sequencing on successive clk_bps pulses, with bit_cnt counting pulses from 1:
- pulse 1: uart_tx=0 (start bit); state goes to SHIFT;
- pulses 2..DATA_W+1: data bits, LSB first;
- next STOP_BITS pulses: uart_tx=1;
- final pulse (DATA_W+2+STOP_BITS, i.e. 11 for defaults): bps_start=0 and enter GAP.
REQ-022 uart_tx SHALL be registered and change only on the edge following a clk_bps pulse; it is high in IDLE, WAIT_START and GAP.
REQ-023 GAP SHALL last exactly 1 cycle with bps_start=0, so the baud generator counter clears, then return to IDLE.
REQ-024 busy SHALL clear when GAP is entered.
REQ-025 Back-to-back: the earliest next acceptance is the cycle after GAP.
REQ-026 clk_bps SHALL be ignored in IDLE and GAP.
REQ-027 A request that drops valid before acceptance SHALL be withdrawn with no side effects.
REQ-028 bit_cnt SHALL be 4 bits, saturating logic not required; values above the final count are unreachable.

Reset
REQ-029 With rst high at a clk edge, the block SHALL set:
- state=IDLE;
- uart_tx=1, bps_start=0, busy=0;
- grant_id=0, last_grant=1, bit_cnt=0.
REQ-030 Reset mid-frame SHALL abort the frame at the next edge, driving uart_tx high with no partial stop bit.
REQ-031 reqN_ready SHALL be low while rst is high.

Structure
REQ-032 Shared package uart_pkg SHALL hold the state enumeration, CLK_PERIOD_NS=40, the BPS_9600 divisor constant 2604, and the frame-length function DATA_W+2+STOP_BITS.
REQ-033 One sub-module, rr_arb2, SHALL implement the two-input round-robin grant and last_grant pointer; the frame sequencer stays in uart_tx_sched.

Verification
REQ-034 Single request: req0 sends 8'hA5 with clk_bps every 2604 cycles (first pulse 1302 cycles after bps_start) -> uart_tx shows 0,1,0,1,0,0,1,0,1,1; bps_start drops on pulse 11; busy low 1 cycle later.
REQ-035 Contention: req0 and req1 held valid with 8'h11 and 8'h22 from reset -> frames sent in order 11,22,11,22; grant_id alternates 0,1,0,1; no idle gap beyond GAP plus 1 cycle.
REQ-036 Withdrawal: req1_valid pulses 1 cycle while busy -> no acceptance; req1_ready is never high.
REQ-037 Reset mid-frame: rst asserted after pulse 5 -> next edge uart_tx=1, bps_start=0, busy=0; a following req1 frame (8'h3C) is transmitted intact.
REQ-038 Spurious tick: clk_bps pulsed in IDLE -> uart_tx stays 1 and state is unchanged.
REQ-039 STOP_BITS=2 build: 8'h00 frame -> 12 pulses total, with uart_tx high for the last two bit periods.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, timing constants
// and the per-frame baud-pulse count.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    SHIFT,
    GAP
  } tx_state_t;

  localparam int CLK_PERIOD_NS = 40;
  localparam int BPS_9600      = 2604;

  // Pulses per frame: start pulse, data pulses, stop pulses and the closing pulse.
  function automatic int frame_len(input int data_w, input int stop_bits);
    return data_w + 2 + stop_bits;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last granted requester
// and advances only when a grant is actually taken.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic grant0,
  output logic grant1
);

  logic last_grant;
  logic pick1;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    pick1 = 1'b0;
    if (req1_valid && !req0_valid) begin
      pick1 = 1'b1;
    end else if (req0_valid && req1_valid) begin
      pick1 = ~last_grant;
    end
  end

  assign grant0 = en && req0_valid && !pick1;
  assign grant1 = en && req1_valid && pick1;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      last_grant <= grant1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmitter: arbitrates a byte, enables the external baud
// generator and serialises start, data (LSB first) and stop bits on clk_bps ticks.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              bps_start,
  input  logic              clk_bps,
  output logic              uart_tx,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [3:0] LAST_DATA  = 4'(DATA_W + 1);
  localparam logic [3:0] LAST_PULSE = 4'(frame_len(DATA_W, STOP_BITS));

  tx_state_t         state, state_nx;
  logic [3:0]        bit_cnt, bit_cnt_nx, pulse_no;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic              tx_nx, bps_nx, busy_nx, gid_nx;
  logic              grant0, grant1, xfer, arb_en;

  // Ready is withheld during reset so nothing can be accepted on the reset edge.
  assign arb_en = (state == IDLE) && !rst;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (arb_en),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 || grant1;
  assign pulse_no   = bit_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      uart_tx   <= 1'b1;
      bps_start <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= 1'b0;
      bit_cnt   <= 4'd0;
      shreg     <= '0;
    end else begin
      state     <= state_nx;
      uart_tx   <= tx_nx;
      bps_start <= bps_nx;
      busy      <= busy_nx;
      grant_id  <= gid_nx;
      bit_cnt   <= bit_cnt_nx;
      shreg     <= shreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (xfer) state_nx = WAIT_START;
      WAIT_START: if (clk_bps) state_nx = SHIFT;
      SHIFT:      if (clk_bps && (pulse_no == LAST_PULSE)) state_nx = GAP;
      GAP:        state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // The payload is copied into a shift register at acceptance, so later changes
  // on reqN_data cannot leak into the frame.
  always_comb begin
    tx_nx      = uart_tx;
    bps_nx     = bps_start;
    busy_nx    = busy;
    gid_nx     = grant_id;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    case (state)
      IDLE: begin
        if (xfer) begin
          shreg_nx   = grant1 ? req1_data : req0_data;
          gid_nx     = grant1;
          bps_nx     = 1'b1;
          busy_nx    = 1'b1;
          bit_cnt_nx = 4'd0;
        end
      end
      WAIT_START: begin
        if (clk_bps) begin
          tx_nx      = 1'b0;
          bit_cnt_nx = 4'd1;
        end
      end
      SHIFT: begin
        if (clk_bps) begin
          bit_cnt_nx = pulse_no;
          if (pulse_no <= LAST_DATA) begin
            tx_nx    = shreg[0];
            shreg_nx = shreg >> 1;
          end else begin
            tx_nx = 1'b1;
          end
          if (pulse_no == LAST_PULSE) begin
            bps_nx  = 1'b0;
            busy_nx = 1'b0;
          end
        end
      end
      GAP: begin
        tx_nx   = 1'b1;
        bps_nx  = 1'b0;
        busy_nx = 1'b0;
      end
      default: tx_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised and directed bench for uart_tx_sched against a frame-level reference
// model plus a line decoder; a second instance covers the two-stop-bit build.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int DW     = 8;
  localparam int FRAME  = frame_len(DW, 1);
  localparam int FRAME2 = frame_len(DW, 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, bps_start, uart_tx, busy, grant_id;
  logic gen_tick = 1'b0, spur_tick = 1'b0;
  logic clk_bps;
  int   bps_div = BPS_9600;
  int   bcnt = 0;

  logic s2_valid = 1'b0, s2_v1 = 1'b0;
  logic [DW-1:0] s2_data = '0, s2_d1 = '0;
  logic s2_ready, s2_r1, s2_bps, s2_tx, s2_busy, s2_gid;
  logic s2_tick = 1'b0;
  int   bcnt2 = 0;

  int compared = 0, mismatched = 0;
  bit done = 1'b0;

  assign clk_bps = gen_tick | spur_tick;

  always #(CLK_PERIOD_NS/2) clk = ~clk;

  uart_tx_sched #(.DATA_W(DW), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .bps_start(bps_start), .clk_bps(clk_bps), .uart_tx(uart_tx),
    .busy(busy), .grant_id(grant_id)
  );

  uart_tx_sched #(.DATA_W(DW), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(s2_valid), .req0_data(s2_data), .req0_ready(s2_ready),
    .req1_valid(s2_v1), .req1_data(s2_d1), .req1_ready(s2_r1),
    .bps_start(s2_bps), .clk_bps(s2_tick), .uart_tx(s2_tx),
    .busy(s2_busy), .grant_id(s2_gid)
  );

  // External baud generators: first tick half a bit after enable, then one per bit.
  always @(posedge clk) begin
    if (!bps_start) begin
      bcnt <= 0; gen_tick <= 1'b0;
    end else begin
      bcnt     <= (bcnt == bps_div-1) ? 0 : bcnt + 1;
      gen_tick <= (((bcnt + 1) % bps_div) == bps_div/2);
    end
  end

  always @(posedge clk) begin
    if (!s2_bps) begin
      bcnt2 <= 0; s2_tick <= 1'b0;
    end else begin
      bcnt2   <= (bcnt2 == 5) ? 0 : bcnt2 + 1;
      s2_tick <= (((bcnt2 + 1) % 6) == 3);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line levels, one per baud pulse.
  bit m_active, m_gap, m_tx, m_bps, m_busy, m_gid, m_last, mon_en = 1'b0;
  bit w0, w1;
  int m_pulses, accepted = 0;
  bit m_bits[$];
  logic [DW-1:0] m_d;

  function automatic void modelReset();
    m_active = 0; m_gap = 0; m_tx = 1; m_bps = 0; m_busy = 0;
    m_gid = 0; m_last = 1; m_pulses = 0;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      w0 = !rst && !m_active && !m_gap && req0_valid && (!req1_valid || m_last);
      w1 = !rst && !m_active && !m_gap && req1_valid && (!req0_valid || !m_last);
      checkOutput("req0_ready", req0_ready, w0);
      checkOutput("req1_ready", req1_ready, w1);
      checkOutput("uart_tx", uart_tx, m_tx);
      checkOutput("bps_start", bps_start, m_bps);
      checkOutput("busy", busy, m_busy);
      checkOutput("grant_id", grant_id, m_gid);
      if (rst) begin
        modelReset();
      end else if (w0 || w1) begin
        m_d = w1 ? req1_data : req0_data;
        m_bits.delete();
        m_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) m_bits.push_back(m_d[i]);
        m_bits.push_back(1'b1);
        m_active = 1; m_pulses = 0; m_gid = w1; m_last = w1;
        m_bps = 1; m_busy = 1; accepted++;
      end else if (m_active && clk_bps) begin
        m_pulses++;
        m_tx = (m_pulses <= m_bits.size()) ? m_bits[m_pulses-1] : 1'b1;
        if (m_pulses == FRAME) begin
          m_active = 0; m_gap = 1; m_bps = 0; m_busy = 0; m_tx = 1;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end
    end
  end

  // Line decoder: samples the line after each baud pulse and rebuilds bytes.
  bit cap_pend = 1'b0, cap2_pend = 1'b0;
  bit cur[$], line_log[$], line2[$];
  logic [DW-1:0] rx_bytes[$];
  bit rx_gids[$];
  logic [DW-1:0] rx_b;
  int pulse_cnt = 0, r1_hits = 0;

  always @(negedge clk) begin
    if (req1_ready === 1'b1) r1_hits++;
    if (rst) begin
      cap_pend = 0; cur.delete();
    end else begin
      if (cap_pend) begin
        cur.push_back(uart_tx); line_log.push_back(uart_tx); cap_pend = 0;
        if (cur.size() == FRAME) begin
          for (int i = 0; i < DW; i++) rx_b[i] = cur[i+1];
          rx_bytes.push_back(rx_b); rx_gids.push_back(grant_id); cur.delete();
        end
      end
      if (clk_bps && bps_start) begin cap_pend = 1; pulse_cnt++; end
    end
    if (cap2_pend) begin line2.push_back(s2_tx); cap2_pend = 0; end
    if (s2_tick && s2_bps) cap2_pend = 1;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit v0, input logic [DW-1:0] d0,
                               input bit v1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
  endtask

  task automatic waitFrameDone(input int budget, input string tag);
    int n = 0;
    while ((busy || bps_start) && n < budget) begin waitCycles(1); n++; end
    checkOutput({tag, "_done_in_time"}, n < budget, 1);
    waitCycles(2);
  endtask

  bit t1_exp [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic [DW-1:0] t2_exp [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
  bit t2_gid [4] = '{0, 1, 0, 1};

  initial begin
    int n, acc0, p0, hits0;
    modelReset();
    applyStimulus(0, '0, 0, '0);
    waitCycles(1);
    mon_en = 1;
    waitCycles(2);
    rst = 0;
    checkOutput("rst_uart_tx", uart_tx, 1);
    checkOutput("rst_bps_start", bps_start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant_id", grant_id, 0);

    $display("[TB] single 8'hA5 frame at 9600 baud");
    bps_div = BPS_9600; line_log.delete(); rx_bytes.delete(); rx_gids.delete();
    applyStimulus(1, 8'hA5, 0, '0);
    waitCycles(1);
    applyStimulus(0, 8'h5A, 0, '0);
    waitFrameDone(40000, "t1");
    checkOutput("t1_pulses", line_log.size(), FRAME);
    for (int i = 0; i < 10 && i < line_log.size(); i++) checkOutput("t1_line_bit", line_log[i], t1_exp[i]);
    checkOutput("t1_frames", rx_bytes.size(), 1);
    if (rx_bytes.size() > 0) checkOutput("t1_byte", rx_bytes[0], 8'hA5);

    $display("[TB] contention from reset");
    bps_div = 6; rx_bytes.delete(); rx_gids.delete();
    rst = 1; acc0 = accepted;
    applyStimulus(1, 8'h11, 1, 8'h22);
    waitCycles(1);
    rst = 0;
    n = 0;
    while ((accepted - acc0) < 4 && n < 2000) begin waitCycles(1); n++; end
    checkOutput("t2_four_accepts", n < 2000, 1);
    applyStimulus(0, '0, 0, '0);
    waitFrameDone(500, "t2");
    checkOutput("t2_frames", rx_bytes.size(), 4);
    for (int i = 0; i < 4 && i < rx_bytes.size(); i++) begin
      checkOutput("t2_byte", rx_bytes[i], t2_exp[i]);
      checkOutput("t2_gid", rx_gids[i], t2_gid[i]);
    end

    $display("[TB] withdrawal while busy");
    rx_bytes.delete(); rx_gids.delete();
    applyStimulus(1, 8'h96, 0, '0);
    waitCycles(1);
    applyStimulus(0, '0, 0, '0);
    waitCycles(20);
    hits0 = r1_hits;
    applyStimulus(0, '0, 1, 8'hC3);
    waitCycles(1);
    applyStimulus(0, '0, 0, '0);
    waitFrameDone(500, "t3");
    waitCycles(3);
    checkOutput("t3_req1_ready_hits", r1_hits - hits0, 0);
    checkOutput("t3_frames", rx_bytes.size(), 1);
    if (rx_bytes.size() > 0) checkOutput("t3_byte", rx_bytes[0], 8'h96);

    $display("[TB] reset mid-frame");
    rx_bytes.delete(); rx_gids.delete();
    p0 = pulse_cnt;
    applyStimulus(1, 8'hF0, 0, '0);
    waitCycles(1);
    applyStimulus(0, '0, 0, '0);
    n = 0;
    while ((pulse_cnt - p0) < 5 && n < 500) begin waitCycles(1); n++; end
    checkOutput("t4_reached_pulse5", n < 500, 1);
    rst = 1;
    waitCycles(1);
    checkOutput("t4_abort_uart_tx", uart_tx, 1);
    checkOutput("t4_abort_bps_start", bps_start, 0);
    checkOutput("t4_abort_busy", busy, 0);
    rst = 0;
    applyStimulus(0, '0, 1, 8'h3C);
    waitCycles(1);
    applyStimulus(0, '0, 0, '0);
    waitFrameDone(500, "t4");
    checkOutput("t4_frames", rx_bytes.size(), 1);
    if (rx_bytes.size() > 0) begin
      checkOutput("t4_byte", rx_bytes[0], 8'h3C);
      checkOutput("t4_gid", rx_gids[0], 1);
    end

    $display("[TB] spurious tick in idle");
    rx_bytes.delete(); rx_gids.delete();
    waitCycles(3);
    spur_tick = 1;
    waitCycles(1);
    spur_tick = 0;
    checkOutput("t5_uart_tx", uart_tx, 1);
    checkOutput("t5_busy", busy, 0);
    applyStimulus(1, 8'h5C, 0, '0);
    #1;
    checkOutput("t5_still_idle_ready", req0_ready, 1);
    waitCycles(1);
    applyStimulus(0, '0, 0, '0);
    waitFrameDone(500, "t5");
    if (rx_bytes.size() > 0) checkOutput("t5_byte", rx_bytes[0], 8'h5C);
    else checkOutput("t5_frames", rx_bytes.size(), 1);

    $display("[TB] randomised traffic");
    bps_div = 5;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, DW'($urandom),
                    $urandom_range(0, 2) != 0, DW'($urandom));
      spur_tick = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      waitCycles(1);
    end
    applyStimulus(0, '0, 0, '0);
    spur_tick = 0; rst = 0;
    waitFrameDone(500, "t6");

    $display("[TB] two-stop-bit instance, 8'h00");
    line2.delete();
    s2_valid = 1; s2_data = 8'h00;
    waitCycles(1);
    s2_valid = 0; s2_data = 8'hFF;
    n = 0;
    while ((s2_busy || s2_bps) && n < 1000) begin waitCycles(1); n++; end
    checkOutput("t7_done_in_time", n < 1000, 1);
    waitCycles(2);
    checkOutput("t7_pulses", line2.size(), FRAME2);
    for (int i = 0; i < FRAME2 && i < line2.size(); i++)
      checkOutput("t7_line_bit", line2[i], (i >= DW + 1) ? 1 : 0);
    checkOutput("t7_busy", s2_busy, 0);

    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #(CLK_PERIOD_NS * 90000);
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL watchdog: got timeout expected completion at %0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

endmodule
